// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encoding, frame geometry, timing defaults.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } ps2_state_t;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_LEN   = 11;
   // bit counter value of the stop bit (counter starts at the first data bit)
   localparam int PS2_LAST_BIT    = PS2_FRAME_LEN - 2;
   localparam int PS2_FILTER_LEN  = 8;
   // 250 us at 50 MHz
   localparam int PS2_TIMEOUT_CYC = 12500;

   // Odd parity over data+parity, and a high stop bit.
   function automatic logic ps2_frame_ok(input logic [8:0] data_par, input logic stop);
      return (^data_par) & stop;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one raw PS/2 line.
// The output idles high and only moves after FILTER_LEN consecutive samples
// at the new level.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int             CW   = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // bring the asynchronous line into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], din};
   end

   // count consecutive samples that disagree with the output; flip on the last one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= 1'b1;
         cnt  <= '0;
      end else if (sync[1] == dout) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         dout <= sync[1];
         cnt  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// Receive-only PS/2 frame decoder: filters both lines, samples data on each
// filtered clock falling edge, checks parity/stop and emits one byte per frame.
// A watchdog drops partial frames when the device stops clocking.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = PS2_FILTER_LEN,
   parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       psdata,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err,
   output logic       timeout_err
);

   localparam int            WW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYC);
   localparam logic [3:0]    BIT_LAST = 4'(PS2_LAST_BIT);

   logic          kclk_f;
   logic          kdat_f;
   logic          kclk_q;
   logic          fall;

   ps2_state_t    state;
   ps2_state_t    state_nxt;
   logic [3:0]    bitcnt;
   logic [8:0]    sr;        // data bits then parity, first wire bit ends up in sr[0]
   logic          stop_r;
   logic [WW-1:0] wd;

   logic          start_rx;
   logic          shift_en;
   logic          stop_en;
   logic          code_ld;
   logic          wd_to;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ps2_clk),
      .dout  (kclk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (psdata),
      .dout  (kdat_f)
   );

   // previous filtered clock level for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) kclk_q <= 1'b1;
      else        kclk_q <= kclk_f;
   end

   assign fall = kclk_q & ~kclk_f;

   // a falling edge in the same cycle always beats the watchdog
   assign wd_to = (state == ST_RECV) && (wd == WD_MAX) && !fall;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (fall && !kdat_f) state_nxt = ST_RECV;
         ST_RECV: begin
            if (fall && bitcnt == BIT_LAST) state_nxt = ST_CHECK;
            else if (wd_to)                 state_nxt = ST_IDLE;
         end
         ST_CHECK: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // output / datapath control decode
   always_comb begin
      start_rx    = (state == ST_IDLE) && fall && !kdat_f;
      shift_en    = (state == ST_RECV) && fall && (bitcnt != BIT_LAST);
      stop_en     = (state == ST_RECV) && fall && (bitcnt == BIT_LAST);
      // code is written on the stop edge so it is already new while CHECK pulses code_valid
      code_ld     = stop_en && ps2_frame_ok(sr, kdat_f);
      code_valid  = (state == ST_CHECK) &&  ps2_frame_ok(sr, stop_r);
      frame_err   = (state == ST_CHECK) && !ps2_frame_ok(sr, stop_r);
      timeout_err = wd_to;
   end

   // bit counter, shift register, stop bit and output byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt <= '0;
         sr     <= '0;
         stop_r <= 1'b0;
         code   <= 8'h00;
      end else begin
         if (start_rx || wd_to) begin
            bitcnt <= '0;
            sr     <= '0;
         end else if (shift_en) begin
            sr     <= {kdat_f, sr[8:1]};
            bitcnt <= bitcnt + 1'b1;
         end
         if (stop_en) stop_r <= kdat_f;
         if (code_ld) code   <= sr[7:0];
      end
   end

   // watchdog: cleared by every edge, runs only while a frame is in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         wd <= '0;
      else if (fall || state != ST_RECV)  wd <= '0;
      else if (wd != WD_MAX)              wd <= wd + 1'b1;
   end

endmodule
